// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the execute-side units.
// Holds RV32M decode constants and the mul/div FSM state type.
package rv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] MUL_F3    = 3'd0;
  localparam logic [2:0] MULH_F3   = 3'd1;
  localparam logic [2:0] MULHSU_F3 = 3'd2;
  localparam logic [2:0] MULHU_F3  = 3'd3;
  localparam logic [2:0] DIV_F3    = 3'd4;
  localparam logic [2:0] DIVU_F3   = 3'd5;
  localparam logic [2:0] REM_F3    = 3'd6;
  localparam logic [2:0] REMU_F3   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the issue logic and muldiv_unit.
// master = core side, slave = execution unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_in, kill,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_in, kill,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Applies two's-complement sign to a magnitude and picks a word.
// Shared by the multiply (64-bit) and divide (zero-extended) results.
module muldiv_sign_fix #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] mag,
  input  logic              neg,
  input  logic              sel_hi,
  output logic [XLEN-1:0]   res
);
  logic [2*XLEN-1:0] val;

  always_comb begin
    val = neg ? ((2*XLEN)'(0) - mag) : mag;
    res = sel_hi ? val[2*XLEN-1:XLEN] : val[XLEN-1:0];
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply
// and restoring divide sharing one accumulator and one FSM.
module muldiv_unit
  import rv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input logic         clk,
  input logic         rst,
  muldiv_unit_if.slave bus
);
  md_state_e state, state_n;

  logic [2:0]      op;
  logic [4:0]      rd_q;
  logic            s_a, s_b, dz;
  logic [XLEN-1:0] opnd;
  logic [63:0]     acc;
  logic [32:0]     rem;
  logic [4:0]      cnt;
  logic            busy_q, done_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;

  logic            sa_en, sb_en, is_div;
  logic            neg_a, neg_b, dz_in, ovf_in, fast;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    sa_en = 1'b0;
    sb_en = 1'b0;
    unique case (1'b1)
      (bus.funct3 == MULH_F3),
      (bus.funct3 == DIV_F3),
      (bus.funct3 == REM_F3): begin
        sa_en = 1'b1;
        sb_en = 1'b1;
      end
      (bus.funct3 == MULHSU_F3): sa_en = 1'b1;
      default: ;
    endcase
  end

  assign is_div = bus.funct3[2];
  assign neg_a  = sa_en & bus.rs1_val[XLEN-1];
  assign neg_b  = sb_en & bus.rs2_val[XLEN-1];
  assign a_mag  = neg_a ? (XLEN'(0) - bus.rs1_val) : bus.rs1_val;
  assign b_mag  = neg_b ? (XLEN'(0) - bus.rs2_val) : bus.rs2_val;
  assign dz_in  = is_div & (bus.rs2_val == '0);
  assign ovf_in = is_div & sb_en
                & (bus.rs1_val == 32'h8000_0000)
                & (bus.rs2_val == 32'hFFFF_FFFF);
  assign fast   = EARLY_OUT & (dz_in | ovf_in);

  // One iteration of each algorithm, used in RUN.
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic [33:0] div_diff;

  assign mul_sum  = {1'b0, acc[63:32]}
                  + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign div_sh   = {rem[31:0], acc[31]};
  assign div_diff = {1'b0, div_sh} - {2'b00, opnd};

  logic [63:0]     fx_mag;
  logic            fx_neg, fx_hi;
  logic [XLEN-1:0] fx_res;

  // A zero divisor yields an all-ones quotient whatever the signs.
  always_comb begin
    fx_mag = acc;
    fx_neg = s_a ^ s_b;
    fx_hi  = (op[1:0] != 2'b00);
    if (op[2]) begin
      fx_hi = 1'b0;
      if (op[1]) begin
        fx_mag = {31'd0, rem};
        fx_neg = s_a;
      end else begin
        fx_mag = {32'd0, acc[31:0]};
        fx_neg = (s_a ^ s_b) & ~dz;
      end
    end
  end

  muldiv_sign_fix #(.XLEN(XLEN)) u_fix (
    .mag    (fx_mag),
    .neg    (fx_neg),
    .sel_hi (fx_hi),
    .res    (fx_res)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (bus.start) state_n = fast ? FIX : RUN;
      RUN: begin
        if (bus.kill)         state_n = IDLE;
        else if (cnt == 5'd0) state_n = FIX;
      end
      FIX:  state_n = bus.kill ? IDLE : DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op       <= '0;
      rd_q     <= '0;
      s_a      <= 1'b0;
      s_b      <= 1'b0;
      dz       <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      rem      <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state  <= state_n;
      done_q <= (state == DONE);
      unique case (state)
        IDLE: if (bus.start) begin
          op     <= bus.funct3;
          rd_q   <= bus.rd_in;
          s_a    <= neg_a;
          s_b    <= neg_b;
          dz     <= dz_in;
          opnd   <= is_div ? b_mag : a_mag;
          cnt    <= 5'd31;
          busy_q <= 1'b1;
          if (fast) begin
            acc <= {32'd0, dz_in ? 32'hFFFF_FFFF : 32'h8000_0000};
            rem <= dz_in ? {1'b0, a_mag} : 33'd0;
          end else begin
            acc <= {32'd0, is_div ? a_mag : b_mag};
            rem <= '0;
          end
        end
        RUN: begin
          if (bus.kill) begin
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - 5'd1;
            if (!op[2]) begin
              acc <= {mul_sum, acc[31:1]};
            end else if (!div_diff[33]) begin
              rem <= div_diff[32:0];
              acc <= {acc[63:32], acc[30:0], 1'b1};
            end else begin
              rem <= div_sh;
              acc <= {acc[63:32], acc[30:0], 1'b0};
            end
          end
        end
        FIX: begin
          if (bus.kill) begin
            busy_q <= 1'b0;
          end else begin
            result_q <= fx_res;
            rd_out_q <= rd_q;
          end
        end
        DONE: busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors,
// fast paths, kill, ignored restart and mid-op reset.
module tb_muldiv_unit;
  import rv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   ndone = 0;
  int   total = 0;
  int   npass = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act === req) npass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      exp_t e;
      ndone++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(ndone), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("rd_out", {27'd0, bus.rd_out}, {27'd0, e.rd});
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
      end
    end
  end

  task automatic drive(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       output int e0);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.funct3  = f3;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_in   = rd;
    @(posedge clk);
    #1;
    e0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run(input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd,
                     input logic [31:0] res, input int lat,
                     input bit chk_busy, input bit poke);
    int e0;
    int nd;
    int busy_low;
    nd = ndone;
    busy_low = 0;
    drive(f3, a, b, rd, e0);
    sb.push_back('{res: res, rd: rd, cyc: e0 + lat});
    if (chk_busy && bus.busy !== 1'b1) busy_low++;
    for (int i = 0; i < 60 && ndone == nd; i++) begin
      if (poke && i == 5) begin
        bus.start   = 1'b1;
        bus.funct3  = DIVU_F3;
        bus.rs1_val = 32'd1000;
        bus.rs2_val = 32'd3;
        bus.rd_in   = 5'd31;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      #1;
      if (chk_busy && ndone == nd && bus.done !== 1'b1
          && bus.busy !== 1'b1) busy_low++;
    end
    bus.start = 1'b0;
    chk("one_done_per_op", 32'(ndone - nd), 32'd1);
    if (chk_busy) chk("busy_during_op", 32'(busy_low), 32'd0);
  endtask

  initial begin
    int e0;
    int nd;
    bus.start   = 1'b0;
    bus.funct3  = '0;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    bus.rd_in   = '0;
    bus.kill    = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst_done",   {31'd0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_rd_out", {27'd0, bus.rd_out}, 32'd0);
    rst = 1'b0;

    run(MUL_F3,    32'd7,         32'hFFFF_FFFD, 5'd5,
        32'hFFFF_FFEB, 34, 1'b1, 1'b0);
    run(MULH_F3,   32'h8000_0000, 32'h8000_0000, 5'd6,
        32'h4000_0000, 34, 1'b0, 1'b0);
    run(MULHU_F3,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,
        32'hFFFF_FFFE, 34, 1'b0, 1'b0);
    run(MULHSU_F3, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8,
        32'hFFFF_FFFF, 34, 1'b0, 1'b0);
    run(DIV_F3,    32'hFFFF_FFF9, 32'd2,         5'd9,
        32'hFFFF_FFFD, 34, 1'b0, 1'b0);
    run(REM_F3,    32'hFFFF_FFF9, 32'd2,         5'd10,
        32'hFFFF_FFFF, 34, 1'b0, 1'b0);
    run(DIVU_F3,   32'd100,       32'd7,         5'd0,
        32'd14,        34, 1'b0, 1'b0);
    run(REMU_F3,   32'd100,       32'd7,         5'd11,
        32'd2,         34, 1'b0, 1'b0);
    run(DIVU_F3,   32'd5,         32'd0,         5'd12,
        32'hFFFF_FFFF, 2,  1'b0, 1'b0);
    run(REM_F3,    32'd5,         32'd0,         5'd13,
        32'd5,         2,  1'b0, 1'b0);
    run(DIV_F3,    32'h8000_0000, 32'hFFFF_FFFF, 5'd14,
        32'h8000_0000, 2,  1'b0, 1'b0);
    run(REM_F3,    32'h8000_0000, 32'hFFFF_FFFF, 5'd15,
        32'd0,         2,  1'b0, 1'b0);
    run(DIV_F3,    32'hFFFF_FFF9, 32'd0,         5'd16,
        32'hFFFF_FFFF, 2,  1'b0, 1'b0);
    run(REM_F3,    32'hFFFF_FFF9, 32'd0,         5'd17,
        32'hFFFF_FFF9, 2,  1'b0, 1'b0);

    // Restart attempt mid-op must be ignored.
    run(MUL_F3, 32'd5, 32'd6, 5'd3, 32'd30, 34, 1'b1, 1'b1);

    // Kill during RUN.
    nd = ndone;
    drive(MUL_F3, 32'd7, 32'd9, 5'd4, e0);
    repeat (9) @(negedge clk);
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    chk("kill_busy_drop", {31'd0, bus.busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("kill_no_done", 32'(ndone - nd), 32'd0);
    chk("kill_result_kept", bus.result, 32'd30);
    chk("kill_rd_kept", {27'd0, bus.rd_out}, 32'd3);

    // Reset mid-op.
    nd = ndone;
    drive(MUL_F3, 32'd11, 32'd13, 5'd20, e0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("midrst_done",   {31'd0, bus.done}, 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    chk("midrst_rd_out", {27'd0, bus.rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_no_done", 32'(ndone - nd), 32'd0);

    run(MUL_F3, 32'd3, 32'd4, 5'd21, 32'd12, 34, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, between the register-file read ports and the register-file write port.
- Consumes the rs1/rs2 operand values and rd index, computes over multiple cycles, and returns the result with rd for a single write-back.
- Radix-2 shift-add multiplier and restoring divider share one datapath and one FSM.
- The core stalls on busy.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- EARLY_OUT, 1, when 1, divide-by-zero and signed overflow complete on the fast path.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- funct3  in  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_val  in  XLEN  operand A (dividend/multiplicand).
- rs2_val  in  XLEN  operand B (divisor/multiplier).
- rd_in  in  5  destination index.
- kill  in  1  synchronous abort of the in-flight op.
- busy  out  1  op accepted and not yet done.
- done  out  1  one-cycle pulse; result/rd_out valid.
- result  out  XLEN  registered result; held until the next accepted start.
- rd_out  out  5  captured rd_in; held with result.

Behaviour:
- Reset values (asynchronous on rst, any state): FSM=IDLE, busy=0, done=0, result=0, rd_out=0, counter=0, all internal accumulators=0.
- FSM states:
  - IDLE: start=1 at edge E0 captures funct3, rd_in and operands. Goes to RUN, or to FIX if the fast path applies. busy=1 from E0.
  - RUN: 32 iterations, counter 31 down to 0, one bit per cycle. After the counter=0 iteration, goes to FIX.
  - FIX: applies sign correction, selects the low/high word or quotient/remainder, registers result and rd_out. Goes to DONE.
  - DONE: done=1, busy=0 for exactly one cycle, then IDLE.
- Latency:
  - Normal op: done is high in the cycle after edge E0+34.
  - Fast path: done is high in the cycle after edge E0+2.
  - A new start is accepted in IDLE only; the earliest is the edge after DONE.
- start while not in IDLE: ignored, with no effect on the in-flight op.
- Signedness:
  - Operands are converted to magnitudes per op (MULHSU: rs1 signed, rs2 unsigned).
  - Product sign = sA XOR sB.
  - Quotient sign = sA XOR sB; remainder sign = sA.
  - Negation is two's complement over 64 bits (mul) or 32 bits (div).
- Multiply uses a 64-bit accumulator. MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide is restoring, with a 33-bit partial remainder.
- Divide by zero (rs2=0), regardless of EARLY_OUT:
  - DIV/DIVU quotient = 0xFFFFFFFF.
  - REM/REMU result = rs1_val.
- Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- kill=1 in RUN or FIX: next state IDLE, busy=0, no done pulse, result and rd_out unchanged.
- kill=1 in IDLE or DONE: no effect; the done pulse in DONE still occurs.
- kill and start both high in IDLE: start wins.
- rd_in=0: computed and signalled normally. Suppressing the write to x0 is the register file's job.
- rst asserted mid-op: immediate return to reset values, and no done pulse after rst deasserts.

Decomposition:
- Shared package rv_pkg holds:
  - funct3 encodings MUL_F3..REMU_F3.
  - OPCODE_OP (0110011) and FUNCT7_MULDIV (0000001), for the decoder that drives start.
  - FSM state enumeration IDLE/RUN/FIX/DONE.
- Sub-module muldiv_sign_fix: combinational magnitude-in/signed-out correction and word select used in FIX, reused for both mul and div paths.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB, rd_out=rd_in, done exactly 1 cycle after edge E0+34, busy=1 throughout.
- MULH 0x80000000*0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
- DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0. All with done one cycle after edge E0+2 when EARLY_OUT=1.
- Start MUL, assert kill at iteration 10 -> no done, busy drops next cycle, result keeps the prior value. A second start pulse mid-op leaves the first op's result intact.
- Assert rst at iteration 20 -> busy, done, result and rd_out all 0 immediately. A following MUL 3*4 -> 12, correct on its first run.
